vga_scan_ctrl: RTL

//  Scan controller for the 640x480@60 display path: owns the horizontal/vertical

---
 rtl/vga_scan_if.sv | 23 ++
 rtl/vga_scan_ctrl.sv | 123 ++++++++++++
 2 files changed

// File: rtl/vga_scan_if.sv
// Scan-controller bundle: run request in, counters, syncs and strobes out.
// master = scan controller, slave = colour/sprite consumer that owns run.
interface vga_scan_if;
  logic        run;
  logic        running;
  logic [15:0] Hout;
  logic [15:0] Vout;
  logic        hsync;
  logic        vsync;
  logic        active;
  logic        line_tick;
  logic        frame_tick;

  modport master (
    input  run,
    output running, Hout, Vout, hsync, vsync, active, line_tick, frame_tick
  );

  modport slave (
    output run,
    input  running, Hout, Vout, hsync, vsync, active, line_tick, frame_tick
  );
endinterface

// File: rtl/vga_scan_ctrl.sv
// VGA scan controller with run/stop handshake; every output is a register decoded from
// the next count (zero skew); stop requests take effect only at the frame boundary.
module vga_scan_ctrl #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33
) (
  input  logic       clk,
  input  logic       reset,
  vga_scan_if.master bus
);
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [15:0] H_LAST   = 16'(H_TOTAL - 1);
  localparam logic [15:0] V_LAST   = 16'(V_TOTAL - 1);
  localparam logic [15:0] H_VIS    = 16'(H_ACTIVE);
  localparam logic [15:0] V_VIS    = 16'(V_ACTIVE);
  localparam logic [15:0] HS_START = 16'(H_ACTIVE + H_FP);
  localparam logic [15:0] HS_END   = 16'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [15:0] VS_START = 16'(V_ACTIVE + V_FP);
  localparam logic [15:0] VS_END   = 16'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_hout, r_vout;
  logic        r_running, r_hsync, r_vsync, r_active, r_line_tick, r_frame_tick;
  logic [15:0] w_hout_nxt, w_vout_nxt;
  logic        w_running, w_hsync, w_vsync, w_active, w_line_tick, w_frame_tick;
  logic        w_line_end, w_frame_end;

  assign w_line_end  = (r_hout == H_LAST);
  assign w_frame_end = w_line_end && (r_vout == V_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // RUN and DRAIN count identically; DRAIN only remembers a pending stop.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.run) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (!bus.run) w_state_nxt = w_frame_end ? S_IDLE : S_DRAIN;
      end
      S_DRAIN: begin
        if (bus.run)          w_state_nxt = S_RUN;
        else if (w_frame_end) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Leaving IDLE presents pixel 0,0 first, so counting only advances from RUN/DRAIN.
  always_comb begin
    w_running  = (w_state_nxt != S_IDLE);
    w_hout_nxt = 16'd0;
    w_vout_nxt = 16'd0;
    if (w_running && (r_state != S_IDLE)) begin
      if (w_line_end) begin
        w_hout_nxt = 16'd0;
        w_vout_nxt = (r_vout == V_LAST) ? 16'd0 : r_vout + 16'd1;
      end else begin
        w_hout_nxt = r_hout + 16'd1;
        w_vout_nxt = r_vout;
      end
    end
    w_hsync      = !(w_running && (w_hout_nxt >= HS_START) && (w_hout_nxt < HS_END));
    w_vsync      = !(w_running && (w_vout_nxt >= VS_START) && (w_vout_nxt < VS_END));
    w_active     = w_running && (w_hout_nxt < H_VIS) && (w_vout_nxt < V_VIS);
    w_line_tick  = w_running && (w_hout_nxt == H_LAST);
    w_frame_tick = w_line_tick && (w_vout_nxt == V_LAST);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hout       <= 16'd0;
      r_vout       <= 16'd0;
      r_running    <= 1'b0;
      r_hsync      <= 1'b1;
      r_vsync      <= 1'b1;
      r_active     <= 1'b0;
      r_line_tick  <= 1'b0;
      r_frame_tick <= 1'b0;
    end else begin
      r_hout       <= w_hout_nxt;
      r_vout       <= w_vout_nxt;
      r_running    <= w_running;
      r_hsync      <= w_hsync;
      r_vsync      <= w_vsync;
      r_active     <= w_active;
      r_line_tick  <= w_line_tick;
      r_frame_tick <= w_frame_tick;
    end
  end

  assign bus.Hout       = r_hout;
  assign bus.Vout       = r_vout;
  assign bus.running    = r_running;
  assign bus.hsync      = r_hsync;
  assign bus.vsync      = r_vsync;
  assign bus.active     = r_active;
  assign bus.line_tick  = r_line_tick;
  assign bus.frame_tick = r_frame_tick;
endmodule
